// File: rtl/sc_scbc_upseq.sv
// Upstream port sequencer: connect debounce, port reset, suspend/resume and PHY line-state handshake.
// Define SC_SCBC_UPSEQ_EVQ_EN to build the port event queue; otherwise its outputs are tied to zero.
module sc_scbc_upseq #(
    parameter int TMR_WIDTH   = 8,
    parameter int DEBOUNCE_MS = 100,
    parameter int RESET_MS    = 50,
    parameter int RESUME_MS   = 20,
    parameter int EVQ_DEPTH   = 4
) (
    input  logic       ULPICLK,
    input  logic       ULPIRST,
    input  logic       CFG_HOST,
    input  logic       CFG_DEVICE,
    input  logic       PRESET_REQ,
    input  logic       PSUSP_REQ,
    input  logic       PRESUME_REQ,
    input  logic [1:0] ULPI_CCS,
    input  logic       FT_1MS,
    output logic       UPSI_REQ,
    input  logic       UPSI_ACK,
    output logic [4:0] UPSI_STATE,
    output logic       UPS_CONNECT,
    output logic       UPS_RESET,
    output logic       UPS_OPERATIONAL,
    output logic       UPS_SUSPEND,
    output logic       UPS_RESUME,
    output logic       EVQ_VALID,
    output logic [2:0] EVQ_DATA,
    input  logic       EVQ_POP,
    input  logic       EVQ_CLR,
    output logic       EVQ_OVF
);

    typedef enum logic [2:0] {
        ST_DISABLED, ST_DISCONNECTED, ST_DEBOUNCE, ST_RESET,
        ST_OPERATIONAL, ST_SUSPEND, ST_RESUME
    } state_t;

    localparam logic [4:0] LS_RESET   = 5'h01;
    localparam logic [4:0] LS_RESUME  = 5'h02;
    localparam logic [4:0] LS_NORMAL  = 5'h03;
    localparam logic [4:0] LS_SUSPEND = 5'h04;

    localparam logic [2:0] EV_CONNECT = 3'd1;
    localparam logic [2:0] EV_DISC    = 3'd2;
    localparam logic [2:0] EV_RSTDONE = 3'd3;
    localparam logic [2:0] EV_SUSP    = 3'd4;
    localparam logic [2:0] EV_RESUMED = 3'd5;

    localparam logic [TMR_WIDTH-1:0] T_ONE = TMR_WIDTH'(1);
    localparam logic [TMR_WIDTH-1:0] T_DEB = TMR_WIDTH'(DEBOUNCE_MS);
    localparam logic [TMR_WIDTH-1:0] T_RST = TMR_WIDTH'(RESET_MS);
    localparam logic [TMR_WIDTH-1:0] T_RES = TMR_WIDTH'(RESUME_MS);

    state_t               state, state_nxt;
    logic [TMR_WIDTH-1:0] tmr, tmr_nxt;
    logic                 req_nxt;
    logic [4:0]           ls_nxt;
    logic                 push;
    logic [2:0]           push_code;
    logic                 mode_ok, host, linked, expire;

    assign mode_ok = CFG_HOST ^ CFG_DEVICE;
    assign host    = mode_ok & CFG_HOST;
    assign linked  = ULPI_CCS != 2'd0;
    assign expire  = FT_1MS && (tmr == T_ONE);

    always_comb begin
        state_nxt = state;
        tmr_nxt   = (FT_1MS && tmr != '0) ? tmr - T_ONE : tmr;
        req_nxt   = UPSI_REQ;
        ls_nxt    = UPSI_STATE;
        push      = 1'b0;
        push_code = 3'd0;
        if (UPSI_REQ) begin
            // Every state change that needs the PHY waits here for its ACK
            if (UPSI_ACK) begin
                req_nxt = 1'b0;
                case (state)
                    ST_RESET, ST_RESUME: begin
                        if (UPSI_STATE == LS_NORMAL) begin
                            state_nxt = ST_OPERATIONAL;
                            push      = 1'b1;
                            push_code = (state == ST_RESET) ? EV_RSTDONE : EV_RESUMED;
                        end else begin
                            tmr_nxt = (state == ST_RESET) ? T_RST : T_RES;
                        end
                    end
                    ST_OPERATIONAL: begin
                        state_nxt = ST_SUSPEND;
                        push      = 1'b1;
                        push_code = EV_SUSP;
                    end
                    default: ;
                endcase
            end
        end else if (!mode_ok) begin
            state_nxt = ST_DISABLED;
            tmr_nxt   = '0;
        end else if (!linked && state inside {ST_RESET, ST_OPERATIONAL,
                                              ST_SUSPEND, ST_RESUME}) begin
            state_nxt = ST_DISCONNECTED;
            tmr_nxt   = '0;
            push      = 1'b1;
            push_code = EV_DISC;
        end else begin
            case (state)
                ST_DISABLED: state_nxt = ST_DISCONNECTED;
                ST_DISCONNECTED: begin
                    if (linked) begin
                        state_nxt = ST_DEBOUNCE;
                        tmr_nxt   = T_DEB;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!linked) begin
                        state_nxt = ST_DISCONNECTED;
                        tmr_nxt   = '0;
                    end else if (expire) begin
                        push      = 1'b1;
                        push_code = EV_CONNECT;
                        if (host) begin
                            state_nxt = ST_RESET;
                            req_nxt   = 1'b1;
                            ls_nxt    = LS_RESET;
                        end else begin
                            state_nxt = ST_OPERATIONAL;
                        end
                    end
                end
                ST_OPERATIONAL: begin
                    if (host && PRESET_REQ) begin
                        state_nxt = ST_RESET;
                        req_nxt   = 1'b1;
                        ls_nxt    = LS_RESET;
                    end else if (host && PSUSP_REQ) begin
                        req_nxt = 1'b1;
                        ls_nxt  = LS_SUSPEND;
                    end
                end
                ST_SUSPEND: begin
                    if (PRESUME_REQ) begin
                        state_nxt = ST_RESUME;
                        req_nxt   = 1'b1;
                        ls_nxt    = LS_RESUME;
                    end
                end
                ST_RESET, ST_RESUME: begin
                    if (expire) begin
                        req_nxt = 1'b1;
                        ls_nxt  = LS_NORMAL;
                    end
                end
                default: state_nxt = ST_DISABLED;
            endcase
        end
    end

    always_ff @(posedge ULPICLK or posedge ULPIRST) begin
        if (ULPIRST) begin
            state           <= ST_DISABLED;
            tmr             <= '0;
            UPSI_REQ        <= 1'b0;
            UPSI_STATE      <= 5'd0;
            UPS_CONNECT     <= 1'b0;
            UPS_RESET       <= 1'b0;
            UPS_OPERATIONAL <= 1'b0;
            UPS_SUSPEND     <= 1'b0;
            UPS_RESUME      <= 1'b0;
        end else begin
            state           <= state_nxt;
            tmr             <= tmr_nxt;
            UPSI_REQ        <= req_nxt;
            UPSI_STATE      <= ls_nxt;
            UPS_CONNECT     <= state_nxt == ST_DEBOUNCE;
            UPS_RESET       <= state_nxt == ST_RESET;
            UPS_OPERATIONAL <= state_nxt == ST_OPERATIONAL;
            UPS_SUSPEND     <= state_nxt == ST_SUSPEND;
            UPS_RESUME      <= state_nxt == ST_RESUME;
        end
    end

`ifdef SC_SCBC_UPSEQ_EVQ_EN
    localparam int PW = $clog2(EVQ_DEPTH);
    localparam int CW = PW + 1;

    logic [2:0]    mem [EVQ_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          full, do_pop, do_wr, ovf_set;

    assign full    = cnt == CW'(EVQ_DEPTH);
    assign do_pop  = EVQ_POP && cnt != '0;
    assign do_wr   = push && (!full || do_pop);
    assign ovf_set = push && full && !do_pop;

    always_ff @(posedge ULPICLK) begin
        if (do_wr) mem[wp] <= push_code;
    end

    always_ff @(posedge ULPICLK or posedge ULPIRST) begin
        if (ULPIRST) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            EVQ_OVF <= 1'b0;
        end else begin
            if (do_wr)  wp <= wp + PW'(1);
            if (do_pop) rp <= rp + PW'(1);
            cnt <= cnt + CW'(do_wr) - CW'(do_pop);
            // A fresh overflow outranks a clear in the same cycle
            if (ovf_set)      EVQ_OVF <= 1'b1;
            else if (EVQ_CLR) EVQ_OVF <= 1'b0;
        end
    end

    assign EVQ_VALID = cnt != '0;
    assign EVQ_DATA  = EVQ_VALID ? mem[rp] : 3'd0;
`else
    logic unused_evq;
    assign unused_evq = ^{push, push_code, EVQ_POP, EVQ_CLR, 5'(EVQ_DEPTH)};
    assign EVQ_VALID  = 1'b0;
    assign EVQ_DATA   = 3'd0;
    assign EVQ_OVF    = 1'b0;
`endif

endmodule

// File: tb/tb_sc_scbc_upseq.sv
// Directed-sequence bench for sc_scbc_upseq with randomized tick gaps, ACK delays and CCS values.
// Event-queue expectations follow SC_SCBC_UPSEQ_EVQ_EN (zero outputs when undefined).
module tb_sc_scbc_upseq;

    localparam int DEB   = 3;
    localparam int RST   = 2;
    localparam int RES   = 4;
    localparam int DEPTH = 4;
`ifdef SC_SCBC_UPSEQ_EVQ_EN
    localparam bit EVQ_EN = 1'b1;
`else
    localparam bit EVQ_EN = 1'b0;
`endif

    localparam logic [4:0] S_CON = 5'b10000;
    localparam logic [4:0] S_RST = 5'b01000;
    localparam logic [4:0] S_OP  = 5'b00100;
    localparam logic [4:0] S_SUS = 5'b00010;
    localparam logic [4:0] S_RES = 5'b00001;

    logic       clk = 1'b0;
    logic       rst, cfg_host, cfg_device, preset_req, psusp_req, presume_req;
    logic [1:0] ccs;
    logic       ft_1ms, upsi_req, upsi_ack;
    logic [4:0] upsi_state;
    logic       ups_connect, ups_reset, ups_operational, ups_suspend, ups_resume;
    logic       evq_valid, evq_pop, evq_clr, evq_ovf;
    logic [2:0] evq_data;

    always #5 clk = ~clk;

    sc_scbc_upseq #(
        .TMR_WIDTH(8), .DEBOUNCE_MS(DEB), .RESET_MS(RST),
        .RESUME_MS(RES), .EVQ_DEPTH(DEPTH)
    ) dut (
        .ULPICLK(clk), .ULPIRST(rst),
        .CFG_HOST(cfg_host), .CFG_DEVICE(cfg_device),
        .PRESET_REQ(preset_req), .PSUSP_REQ(psusp_req), .PRESUME_REQ(presume_req),
        .ULPI_CCS(ccs), .FT_1MS(ft_1ms),
        .UPSI_REQ(upsi_req), .UPSI_ACK(upsi_ack), .UPSI_STATE(upsi_state),
        .UPS_CONNECT(ups_connect), .UPS_RESET(ups_reset),
        .UPS_OPERATIONAL(ups_operational), .UPS_SUSPEND(ups_suspend),
        .UPS_RESUME(ups_resume),
        .EVQ_VALID(evq_valid), .EVQ_DATA(evq_data), .EVQ_POP(evq_pop),
        .EVQ_CLR(evq_clr), .EVQ_OVF(evq_ovf)
    );

    int vectors = 0;
    int miscompares = 0;
    int q[$];
    bit ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] sts();
        return {ups_connect, ups_reset, ups_operational, ups_suspend, ups_resume};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    // Reference event queue: pop first, then a push fits if a slot is free.
    task automatic model_ev(input bit pop, input int code);
        if (pop && q.size() > 0) void'(q.pop_front());
        if (code != 0) begin
            if (q.size() < DEPTH) q.push_back(code);
            else ovf = 1'b1;
        end
    endtask

    task automatic chk_q(input string tag);
        logic ev;
        ev = EVQ_EN && (q.size() > 0);
        chk({tag, ".valid"}, 32'(evq_valid), 32'(ev));
        chk({tag, ".data"}, 32'(evq_data), ev ? q[0] : 0);
        chk({tag, ".ovf"}, 32'(evq_ovf), 32'(EVQ_EN && ovf));
    endtask

    task automatic pop_chk(input string tag);
        evq_pop = 1'b1;
        cyc();
        evq_pop = 1'b0;
        model_ev(1'b1, 0);
        chk_q(tag);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) cyc();
            ft_1ms = 1'b1;
            cyc();
            ft_1ms = 1'b0;
        end
    endtask

    task automatic do_ack(input string tag, input logic [4:0] ls, input int hold,
                          input logic [4:0] exp_sts);
        chk({tag, ".req"}, 32'(upsi_req), 1);
        chk({tag, ".ls"}, 32'(upsi_state), 32'(ls));
        for (int i = 0; i < hold; i++) begin
            cyc();
            chk({tag, ".hold_req"}, 32'(upsi_req), 1);
            chk({tag, ".hold_ls"}, 32'(upsi_state), 32'(ls));
            chk({tag, ".hold_sts"}, 32'(sts()), 32'(exp_sts));
        end
        upsi_ack = 1'b1;
        cyc();
        upsi_ack = 1'b0;
        chk({tag, ".req_drop"}, 32'(upsi_req), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time budget exceeded, %0d vectors applied", vectors);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_host = 1'b1; cfg_device = 1'b0;
        preset_req = 1'b0; psusp_req = 1'b0; presume_req = 1'b0;
        ccs = 2'd0; ft_1ms = 1'b0; upsi_ack = 1'b0;
        evq_pop = 1'b0; evq_clr = 1'b0;
        repeat (3) cyc();
        chk("rst.sts", 32'(sts()), 0);
        chk("rst.req", 32'(upsi_req), 0);
        chk("rst.ls", 32'(upsi_state), 0);
        chk_q("rst.q");
        rst = 1'b0;
        repeat (2) cyc();
        chk("disc.sts", 32'(sts()), 0);

        // Connect dropped mid-debounce: silent return
        ccs = 2'($urandom_range(1, 3));
        cyc();
        chk("deb.sts", 32'(sts()), 32'(S_CON));
        ticks(1);
        ccs = 2'd0;
        cyc();
        chk("abort.sts", 32'(sts()), 0);
        chk_q("abort.q");

        // Host connect, port reset sequence
        ccs = 2'($urandom_range(1, 3));
        cyc();
        ticks(DEB - 1);
        chk("deb2.req", 32'(upsi_req), 0);
        chk("deb2.sts", 32'(sts()), 32'(S_CON));
        ticks(1);
        model_ev(1'b0, 1);
        chk("con.sts", 32'(sts()), 32'(S_RST));
        chk_q("con.q");
        do_ack("rst01", 5'h01, $urandom_range(0, 3), S_RST);
        ticks(RST - 1);
        chk("rsttmr.req", 32'(upsi_req), 0);
        ticks(1);
        do_ack("rst03", 5'h03, $urandom_range(0, 3), S_RST);
        model_ev(1'b0, 3);
        chk("op.sts", 32'(sts()), 32'(S_OP));
        chk_q("op.q");
        pop_chk("pop1");
        pop_chk("pop3");

        // Suspend and resume
        psusp_req = 1'b1;
        cyc();
        chk("susp.sts", 32'(sts()), 32'(S_OP));
        do_ack("susp", 5'h04, $urandom_range(0, 3), S_OP);
        psusp_req = 1'b0;
        model_ev(1'b0, 4);
        chk("susp2.sts", 32'(sts()), 32'(S_SUS));
        repeat (2) cyc();
        chk("susp3.sts", 32'(sts()), 32'(S_SUS));
        presume_req = 1'b1;
        cyc();
        presume_req = 1'b0;
        chk("res.sts", 32'(sts()), 32'(S_RES));
        do_ack("res02", 5'h02, $urandom_range(0, 3), S_RES);
        ticks(RES - 1);
        chk("restmr.req", 32'(upsi_req), 0);
        ticks(1);
        do_ack("res03", 5'h03, $urandom_range(0, 3), S_RES);
        model_ev(1'b0, 5);
        chk("res2.sts", 32'(sts()), 32'(S_OP));
        pop_chk("pop4");
        pop_chk("pop5");

        // Port reset with ACK withheld while the link drops
        preset_req = 1'b1;
        cyc();
        preset_req = 1'b0;
        chk("prst.sts", 32'(sts()), 32'(S_RST));
        ccs = 2'd0;
        do_ack("hold", 5'h01, 10, S_RST);
        chk("hold.after_ack", 32'(sts()), 32'(S_RST));
        cyc();
        model_ev(1'b0, 2);
        chk("hold.disc", 32'(sts()), 0);
        chk_q("hold.q");
        pop_chk("pop2");

        // Device mode: five events, queue overflows
        cfg_host = 1'b0;
        cfg_device = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) begin
                ccs = 2'($urandom_range(1, 3));
                cyc();
                ticks(DEB);
                model_ev(1'b0, 1);
                chk("dev.op", 32'(sts()), 32'(S_OP));
                chk("dev.req", 32'(upsi_req), 0);
            end else begin
                ccs = 2'd0;
                cyc();
                model_ev(1'b0, 2);
                chk("dev.disc", 32'(sts()), 0);
            end
            chk_q("dev.q");
        end
        preset_req = 1'b1;
        psusp_req = 1'b1;
        cyc();
        preset_req = 1'b0;
        psusp_req = 1'b0;
        cyc();
        chk("dev.ign_sts", 32'(sts()), 32'(S_OP));
        chk("dev.ign_req", 32'(upsi_req), 0);
        evq_clr = 1'b1;
        cyc();
        evq_clr = 1'b0;
        ovf = 1'b0;
        chk_q("clr");

        // Push and pop together on a full queue
        ccs = 2'd0;
        evq_pop = 1'b1;
        cyc();
        evq_pop = 1'b0;
        model_ev(1'b1, 2);
        chk_q("pushpop");

        // Overflow and clear in the same cycle: overflow sticks
        ccs = 2'($urandom_range(1, 3));
        cyc();
        ticks(DEB - 1);
        ft_1ms = 1'b1;
        evq_clr = 1'b1;
        cyc();
        ft_1ms = 1'b0;
        evq_clr = 1'b0;
        ovf = 1'b0;
        model_ev(1'b0, 1);
        chk_q("setwins");
        for (int i = 0; i < DEPTH + 1; i++) pop_chk("drain");

        // Invalid mode while operational
        cfg_host = 1'b1;
        cyc();
        chk("inval.sts", 32'(sts()), 0);
        chk("inval.req", 32'(upsi_req), 0);
        cfg_device = 1'b0;
        repeat (2) cyc();
        chk("reval.sts", 32'(sts()), 32'(S_CON));
        ticks(DEB);
        model_ev(1'b0, 1);
        chk("rst2.req", 32'(upsi_req), 1);
        chk("rst2.ls", 32'(upsi_state), 1);

        // Invalid mode waits for the outstanding request
        cfg_device = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("pend.sts", 32'(sts()), 32'(S_RST));
            chk("pend.req", 32'(upsi_req), 1);
        end

        // Reset mid-handshake
        rst = 1'b1;
        cyc();
        q.delete();
        ovf = 1'b0;
        chk("mrst.sts", 32'(sts()), 0);
        chk("mrst.req", 32'(upsi_req), 0);
        chk("mrst.ls", 32'(upsi_state), 0);
        chk_q("mrst.q");
        rst = 1'b0;
        cfg_device = 1'b0;
        upsi_ack = 1'b1;
        repeat (2) cyc();
        upsi_ack = 1'b0;
        chk("stray_ack.req", 32'(upsi_req), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
